// File: rtl/fifo_exerciser.sv
// FIFO exerciser: streams a selectable data pattern into an external FIFO,
// reads it back, checks every beat, and reports errors and watchdog timeout.
module fifo_exerciser #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned CWIDTH = 16,
  parameter int unsigned TWIDTH = 12,
  parameter logic [31:0] SEED   = 32'h0000_0001
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [CWIDTH-1:0] length,
  input  logic [3:0]        wr_gap,
  input  logic [3:0]        rd_gap,
  input  logic              fifo_full,
  output logic              fifo_wdv,
  output logic [DWIDTH-1:0] fifo_wdata,
  input  logic              fifo_empty,
  output logic              fifo_rrq,
  input  logic              fifo_rdv,
  input  logic [DWIDTH-1:0] fifo_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [CWIDTH-1:0] err_count,
  output logic [CWIDTH-1:0] first_err_idx
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          mode_q;
  logic [CWIDTH-1:0]   len_q;
  logic [3:0]          wgap_cfg, rgap_cfg;
  logic [3:0]          wgap_cnt, rgap_cnt;
  logic [CWIDTH-1:0]   wr_cnt, rq_cnt, rd_cnt;
  logic [TWIDTH-1:0]   wdog;
  logic [31:0]         w_lfsr, c_lfsr;
  logic [DWIDTH-1:0]   w_walk, c_walk;
  logic                timeout_q;
  logic [CWIDTH-1:0]   err_q, ferr_q;

  logic                active, start_ok, wr_go, rq_go, rd_beat, rd_exp;
  logic                wdog_hit, mismatch;
  logic [DWIDTH-1:0]   w_data, c_data;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  // Rotate written with shifts so DWIDTH=1 stays legal.
  function automatic logic [DWIDTH-1:0] walk_step(input logic [DWIDTH-1:0] w);
    return (w << 1) | (w >> (DWIDTH - 1));
  endfunction

  function automatic logic [DWIDTH-1:0] gen_data(input logic [1:0]        m,
                                                 input logic [CWIDTH-1:0] idx,
                                                 input logic [31:0]       lf,
                                                 input logic [DWIDTH-1:0] wk);
    case (m)
      2'd1:    return lf[DWIDTH-1:0];
      2'd2:    return wk;
      default: return DWIDTH'(idx);
    endcase
  endfunction

  always_comb begin
    active   = (state_q == RUN) || (state_q == DRAIN);
    start_ok = start && ((state_q == IDLE) || (state_q == DONE));
    wr_go    = (state_q == RUN) && (wr_cnt < len_q) && !fifo_full && (wgap_cnt == '0);
    rq_go    = active && (rq_cnt < len_q) && !fifo_empty && (rgap_cnt == '0);
    rd_beat  = active && fifo_rdv;
    rd_exp   = rd_cnt < len_q;
    wdog_hit = active && (wdog == '1);
    w_data   = gen_data(mode_q, wr_cnt, w_lfsr, w_walk);
    c_data   = gen_data(mode_q, rd_cnt, c_lfsr, c_walk);
    mismatch = rd_beat && (!rd_exp || (fifo_rdata != c_data));
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = RUN;
      RUN: begin
        if (wdog_hit)             state_d = DONE;
        else if (wr_cnt == len_q) state_d = (rd_cnt == len_q) ? DONE : DRAIN;
      end
      DRAIN: begin
        if (wdog_hit || (rd_cnt == len_q)) state_d = DONE;
      end
      DONE:  if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy          = active;
    done          = (state_q == DONE);
    pass          = (state_q == DONE) && (err_q == '0) && !timeout_q;
    fifo_rrq      = rq_go;
    timeout       = timeout_q;
    err_count     = err_q;
    first_err_idx = ferr_q;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      mode_q     <= '0;
      len_q      <= '0;
      wgap_cfg   <= '0;
      rgap_cfg   <= '0;
      wgap_cnt   <= '0;
      rgap_cnt   <= '0;
      wr_cnt     <= '0;
      rq_cnt     <= '0;
      rd_cnt     <= '0;
      wdog       <= '0;
      w_lfsr     <= SEED;
      c_lfsr     <= SEED;
      w_walk     <= DWIDTH'(1);
      c_walk     <= DWIDTH'(1);
      timeout_q  <= 1'b0;
      err_q      <= '0;
      ferr_q     <= '1;
      fifo_wdv   <= 1'b0;
      fifo_wdata <= '0;
    end else begin
      fifo_wdv <= 1'b0;
      if (start_ok) begin
        mode_q    <= (mode == 2'd3) ? 2'd0 : mode;
        len_q     <= length;
        wgap_cfg  <= wr_gap;
        rgap_cfg  <= rd_gap;
        wgap_cnt  <= '0;
        rgap_cnt  <= '0;
        wr_cnt    <= '0;
        rq_cnt    <= '0;
        rd_cnt    <= '0;
        wdog      <= '0;
        w_lfsr    <= SEED;
        c_lfsr    <= SEED;
        w_walk    <= DWIDTH'(1);
        c_walk    <= DWIDTH'(1);
        timeout_q <= 1'b0;
        err_q     <= '0;
        ferr_q    <= '1;
      end else if (active) begin
        if (wr_go) begin
          fifo_wdv   <= 1'b1;
          fifo_wdata <= w_data;
          wr_cnt     <= wr_cnt + CWIDTH'(1);
          w_lfsr     <= lfsr_step(w_lfsr);
          w_walk     <= walk_step(w_walk);
          wgap_cnt   <= wgap_cfg;
        end else if (wgap_cnt != '0) begin
          wgap_cnt <= wgap_cnt - 4'd1;
        end

        if (rq_go) begin
          rq_cnt   <= rq_cnt + CWIDTH'(1);
          rgap_cnt <= rgap_cfg;
        end else if (rgap_cnt != '0) begin
          rgap_cnt <= rgap_cnt - 4'd1;
        end

        // Beats beyond length are errors but do not advance the checker.
        if (rd_beat && rd_exp) begin
          rd_cnt <= rd_cnt + CWIDTH'(1);
          c_lfsr <= lfsr_step(c_lfsr);
          c_walk <= walk_step(c_walk);
        end
        if (mismatch) begin
          if (err_q != '1) err_q <= err_q + CWIDTH'(1);
          if (err_q == '0) ferr_q <= rd_cnt;
        end

        if (wr_go || rq_go || rd_beat) wdog <= '0;
        else if (wdog_hit)             timeout_q <= 1'b1;
        else                           wdog <= wdog + TWIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_exerciser.sv
// Bench for fifo_exerciser: loopback FIFO model, reference pattern queue and
// an independent monitor that scores writes and end-of-run results.
module tb_fifo_exerciser;

  localparam int DW    = 8;
  localparam int CW    = 16;
  localparam int TW    = 6;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          start;
  logic [1:0]    mode;
  logic [CW-1:0] length;
  logic [3:0]    wr_gap, rd_gap;
  logic          fifo_full, fifo_wdv, fifo_empty, fifo_rrq, fifo_rdv;
  logic [DW-1:0] fifo_wdata, fifo_rdata;
  logic          busy, done, pass, timeout;
  logic [CW-1:0] err_count, first_err_idx;

  always #5 clk = ~clk;

  fifo_exerciser #(.DWIDTH(DW), .CWIDTH(CW), .TWIDTH(TW), .SEED(32'h0000_0001)) dut (
    .clk(clk), .arst_n(arst_n), .start(start), .mode(mode), .length(length),
    .wr_gap(wr_gap), .rd_gap(rd_gap), .fifo_full(fifo_full), .fifo_wdv(fifo_wdv),
    .fifo_wdata(fifo_wdata), .fifo_empty(fifo_empty), .fifo_rrq(fifo_rrq),
    .fifo_rdv(fifo_rdv), .fifo_rdata(fifo_rdata), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout), .err_count(err_count), .first_err_idx(first_err_idx)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  typedef struct {
    bit pass;
    bit tmo;
    int err;
    int ferr;
    int nwr;
    int nrd;
  } res_t;

  logic [DW-1:0] exp_wr[$];
  res_t          exp_res[$];

  // Loopback FIFO; full counts the write already in flight.
  logic [DW-1:0] fq[$];
  logic [DW-1:0] fd;
  int            fcnt = 0;
  int            rd_beat_idx = 0;
  int            corrupt_idx = -1;
  bit            force_full = 0;
  bit            hold_empty = 0;

  assign fifo_full  = force_full || ((fcnt + (fifo_wdv ? 1 : 0)) >= DEPTH);
  assign fifo_empty = hold_empty || (fcnt == 0);

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      fq.delete();
      fcnt        <= 0;
      fifo_rdv    <= 1'b0;
      fifo_rdata  <= '0;
      rd_beat_idx = 0;
    end else begin
      fifo_rdv <= 1'b0;
      if (start && !busy) rd_beat_idx = 0;
      if (fifo_rrq && fq.size() > 0) begin
        fd = fq.pop_front();
        if (rd_beat_idx == corrupt_idx) fd[0] = ~fd[0];
        fifo_rdata <= fd;
        fifo_rdv   <= 1'b1;
        rd_beat_idx++;
      end
      if (fifo_wdv) fq.push_back(fifo_wdata);
      fcnt <= fq.size();
    end
  end

  logic full_at_edge = 1'b0;
  always @(posedge clk) full_at_edge <= fifo_full;

  int cyc = 0, nwr = 0, nrd = 0, last_wr_t = 0, done_t = 0;
  bit busy_q = 0, done_q = 0;

  initial begin
    res_t r;
    forever begin
      @(negedge clk);
      if (busy && !busy_q) begin
        nwr = 0;
        nrd = 0;
      end
      if (fifo_wdv) begin
        nwr++;
        last_wr_t = cyc;
        check("write_while_full", {31'd0, full_at_edge}, 32'd0);
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write got=%0h exp=none", fifo_wdata);
        end else begin
          check("wdata", {24'd0, fifo_wdata}, {24'd0, exp_wr.pop_front()});
        end
      end
      if (fifo_rdv) nrd++;
      if (done && !done_q) begin
        done_t = cyc;
        if (exp_res.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done got=1 exp=0");
        end else begin
          r = exp_res.pop_front();
          check("res_pass", {31'd0, pass}, {31'd0, r.pass});
          check("res_timeout", {31'd0, timeout}, {31'd0, r.tmo});
          check("res_err_count", {16'd0, err_count}, r.err);
          check("res_first_err_idx", {16'd0, first_err_idx}, r.ferr);
          check("res_writes", nwr, r.nwr);
          check("res_rdv_beats", nrd, r.nrd);
          check("res_wr_queue_left", exp_wr.size(), 0);
        end
      end
      busy_q = busy;
      done_q = done;
      cyc++;
    end
  end

  task automatic start_run(input int m, input int len, input int wg, input int rg,
                           input bit e_pass, input bit e_to, input int e_err,
                           input int e_ferr, input int e_nwr, input int e_nrd);
    logic [31:0] s;
    res_t r;
    s = 32'h0000_0001;
    for (int n = 0; n < len; n++) begin
      case (m)
        1:       begin exp_wr.push_back(s[7:0]); s = {s[30:0], ^(s & 32'h8020_0003)}; end
        2:       exp_wr.push_back(8'(1 << (n % 8)));
        default: exp_wr.push_back(8'(n % 256));
      endcase
    end
    r.pass = e_pass; r.tmo = e_to; r.err = e_err; r.ferr = e_ferr;
    r.nwr = e_nwr; r.nrd = e_nrd;
    exp_res.push_back(r);
    @(negedge clk);
    mode   = 2'(m);
    length = CW'(len);
    wr_gap = 4'(wg);
    rd_gap = 4'(rg);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        #2;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL done_wait got=busy exp=done within %0d cycles", budget);
    arst_n = 1'b0;
    @(negedge clk);
    exp_wr.delete();
    exp_res.delete();
    arst_n = 1'b1;
  endtask

  initial begin
    int m, len, wg, rg, viol;
    arst_n = 1'b0; start = 1'b0; mode = '0; length = '0; wr_gap = '0; rd_gap = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_pass", {31'd0, pass}, 0);
    check("rst_wdv", {31'd0, fifo_wdv}, 0);
    check("rst_rrq", {31'd0, fifo_rrq}, 0);
    check("rst_first_err_idx", {16'd0, first_err_idx}, 32'hFFFF);
    arst_n = 1'b1;
    repeat (2) @(negedge clk);

    start_run(0, 1717, 0, 0, 1, 0, 0, 'hFFFF, 1717, 1717);
    wait_done(1717 * 4 + 500);

    start_run(1, 300, 3, 0, 1, 0, 0, 'hFFFF, 300, 300);
    wait_done(300 * 8 + 500);

    for (int k = 0; k < 6; k++) begin
      m   = $urandom_range(0, 3);
      len = $urandom_range(0, 60);
      wg  = $urandom_range(0, 15);
      rg  = $urandom_range(0, 15);
      start_run(m, len, wg, rg, 1, 0, 0, 'hFFFF, len, len);
      wait_done(len * 40 + 300);
    end

    start_run(0, 200, 0, 0, 1, 0, 0, 'hFFFF, 200, 200);
    repeat (60) @(negedge clk);
    force_full = 1'b1;
    viol = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (fifo_wdv) viol++;
    end
    force_full = 1'b0;
    check("wdv_during_forced_full", viol, 0);
    wait_done(2000);

    corrupt_idx = 5;
    start_run(2, 20, 0, 0, 0, 0, 1, 5, 20, 20);
    wait_done(1000);
    corrupt_idx = -1;

    hold_empty = 1'b1;
    start_run(0, 10, 0, 0, 0, 1, 0, 'hFFFF, 10, 0);
    wait_done(500);
    check("timeout_latency_le_64", {31'd0, (done_t - last_wr_t) <= 64 && (done_t > last_wr_t)}, 1);
    check("timeout_done", {31'd0, done}, 1);
    hold_empty = 1'b0;

    start_run(1, 100, 0, 2, 1, 0, 0, 'hFFFF, 100, 100);
    repeat (30) @(negedge clk);
    arst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_done", {31'd0, done}, 0);
    check("mid_rst_pass", {31'd0, pass}, 0);
    check("mid_rst_timeout", {31'd0, timeout}, 0);
    check("mid_rst_wdv", {31'd0, fifo_wdv}, 0);
    check("mid_rst_wdata", {24'd0, fifo_wdata}, 0);
    check("mid_rst_rrq", {31'd0, fifo_rrq}, 0);
    check("mid_rst_err_count", {16'd0, err_count}, 0);
    check("mid_rst_first_err_idx", {16'd0, first_err_idx}, 32'hFFFF);
    exp_wr.delete();
    exp_res.delete();
    @(negedge clk);
    arst_n = 1'b1;
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_wdv || fifo_rrq || busy) viol++;
    end
    check("post_rst_no_traffic", viol, 0);

    start_run(0, 0, 0, 0, 1, 0, 0, 'hFFFF, 0, 0);
    check("len0_busy_cycle1", {31'd0, busy}, 1);
    @(negedge clk);
    check("len0_done_cycle2", {31'd0, done}, 1);
    check("len0_pass_cycle2", {31'd0, pass}, 1);
    repeat (5) @(negedge clk);
    check("len0_no_writes", nwr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
